// File: rtl/ram_2x4_arb_pkg.sv
// Shared definitions for the ram_2x4 arbiter slice.
//   DATA_W  : memory word width
//   state_t : sequencer states (encoding 2'd3 is unused and recovers to IDLE)
package ram_arb_pkg;

  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_2x4_arb_if.sv
// Requester-side bus of the ram_2x4 arbiter.
//   req0/req1     : level requests, held until the matching ack
//   rw0/rw1       : 1 = write, 0 = read
//   addr0/addr1   : word address
//   wdata0/wdata1 : write data
//   ack0/ack1     : one-cycle completion pulses
//   rdata         : read data, valid in the ack cycle of a read
//   busy          : sequencer not idle
// master = requesters, slave = arbiter.
interface ram_2x4_arb_if;
  import ram_arb_pkg::*;

  logic              req0, req1;
  logic              rw0, rw1;
  logic              addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata, busy
  );

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata, busy
  );

endinterface

// File: rtl/ram_2x4.sv
// 2-word x 4-bit memory.
//   clk      : clock
//   clr      : synchronous active-high clear of both words
//   we       : write enable, word committed on the rising edge
//   addr     : word address
//   data_in  : write data
//   data_out : asynchronous read of the addressed word
module ram_2x4
  import ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic              addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [2];

  always_ff @(posedge clk) begin
    if (clr) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (we) begin
      mem[addr] <= data_in;
    end
  end

  assign data_out = mem[addr];

endmodule

// File: rtl/ram_2x4_arb.sv
// Round-robin arbiter and access sequencer for one ram_2x4 instance.
//   clk : clock
//   clr : synchronous active-high reset, also clears the memory
//   bus : requester bus (slave side), see ram_2x4_arb_if
// Sequence per transaction: IDLE (arbitrate + latch) -> ACCESS (memory
// cycle) -> RESP (ack to winner) -> IDLE.
module ram_2x4_arb
  import ram_arb_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  ram_2x4_arb_if.slave  bus
);

  state_t            state, state_nx;
  logic              prio, sel;
  logic              cmd_rw, cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] rdata_q, mem_dout;
  logic              grant1, any_req;
  logic              mem_we;
  logic              busy_q, ack0_q, ack1_q;
  logic              busy_nx, ack0_nx, ack1_nx;

  // Requester 1 wins when alone, or under contention when prio favours it.
  assign any_req = bus.req0 | bus.req1;
  assign grant1  = bus.req1 & (~bus.req0 | prio);

  // State register; busy/ack are registered from the next-state decode so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= busy_nx;
      ack0_q <= ack0_nx;
      ack1_q <= ack1_nx;
    end
  end

  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE:   state_nx = any_req ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_we  = (state == ST_ACCESS) && cmd_rw;
    busy_nx = (state_nx != ST_IDLE);
    ack0_nx = (state_nx == ST_RESP) && !sel;
    ack1_nx = (state_nx == ST_RESP) && sel;
  end

  // Command latch, round-robin pointer and read-data capture.
  always_ff @(posedge clk) begin
    if (clr) begin
      prio      <= 1'b0;
      sel       <= 1'b0;
      cmd_rw    <= 1'b0;
      cmd_addr  <= 1'b0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        sel       <= grant1;
        prio      <= ~grant1;
        cmd_rw    <= grant1 ? bus.rw1    : bus.rw0;
        cmd_addr  <= grant1 ? bus.addr1  : bus.addr0;
        cmd_wdata <= grant1 ? bus.wdata1 : bus.wdata0;
      end
      if (state == ST_ACCESS && !cmd_rw) begin
        rdata_q <= mem_dout;
      end
    end
  end

  ram_2x4 u_ram (
    .clk      (clk),
    .clr      (clr),
    .we       (mem_we),
    .addr     (cmd_addr),
    .data_in  (cmd_wdata),
    .data_out (mem_dout)
  );

  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.busy  = busy_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_ram_2x4_arb.sv
module tb_ram_2x4_arb;
  import ram_arb_pkg::*;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  ram_2x4_arb_if bus_if ();

  ram_2x4_arb dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       clr;
    logic       req0, rw0, addr0;
    logic [3:0] wdata0;
    logic       req1, rw1, addr1;
    logic [3:0] wdata1;
    logic       ack0, ack1, busy;
    logic       chk_rd;
    logic [3:0] rdata;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t v(
    input logic c,
    input logic q0, input logic w0, input logic a0, input logic [3:0] d0,
    input logic q1, input logic w1, input logic a1, input logic [3:0] d1,
    input logic k0, input logic k1, input logic b,
    input logic cr, input logic [3:0] rd);
    vec_t t;
    t.clr = c;
    t.req0 = q0; t.rw0 = w0; t.addr0 = a0; t.wdata0 = d0;
    t.req1 = q1; t.rw1 = w1; t.addr1 = a1; t.wdata1 = d1;
    t.ack0 = k0; t.ack1 = k1; t.busy = b;
    t.chk_rd = cr; t.rdata = rd;
    return t;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    clr           = t.clr;
    bus_if.req0   = t.req0;
    bus_if.rw0    = t.rw0;
    bus_if.addr0  = t.addr0;
    bus_if.wdata0 = t.wdata0;
    bus_if.req1   = t.req1;
    bus_if.rw1    = t.rw1;
    bus_if.addr1  = t.addr1;
    bus_if.wdata1 = t.wdata1;
  endtask

  // Read via requester 0 with a bounded wait for ack0.
  task automatic do_read(input logic a, input logic [3:0] exp, input string name);
    int unsigned n;
    bit got;
    n = 0;
    got = 0;
    @(negedge clk);
    bus_if.req0  = 1'b1;
    bus_if.rw0   = 1'b0;
    bus_if.addr0 = a;
    while (!got && n < 6) begin
      @(posedge clk); #1;
      n++;
      if (bus_if.ack0) got = 1;
    end
    check({name, "_latency"}, 4'(n), 4'd2);
    if (got) check({name, "_rdata"}, bus_if.rdata, exp);
    @(negedge clk);
    bus_if.req0 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          clr q0 w0 a0 d0    q1 w1 a1 d1    k0 k1 b  cr rd
    vecs[0]  = v(1, 1, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h0);
    vecs[1]  = v(1, 1, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h0);
    vecs[2]  = v(0, 1, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 4'h0);
    vecs[3]  = v(0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 1, 1, 4'h0);
    vecs[4]  = v(0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h0);
    vecs[5]  = v(0, 1, 0, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 4'h0);
    vecs[6]  = v(0, 1, 0, 1, 4'h0, 0, 0, 0, 4'h0, 1, 0, 1, 1, 4'h0);
    vecs[7]  = v(0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0);
    vecs[8]  = v(0, 1, 1, 1, 4'hA, 0, 0, 0, 4'h0, 0, 0, 1, 0, 4'h0);
    vecs[9]  = v(0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 1, 1, 4'h0);
    vecs[10] = v(0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h0);
    vecs[11] = v(0, 1, 0, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 4'h0);
    vecs[12] = v(0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 1, 1, 4'hA);
    vecs[13] = v(0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 4'hA);
    vecs[14] = v(1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h0);
    vecs[15] = v(0, 1, 1, 0, 4'h3, 1, 0, 0, 4'h0, 0, 0, 1, 0, 4'h0);
    vecs[16] = v(0, 1, 1, 0, 4'h3, 1, 0, 0, 4'h0, 1, 0, 1, 1, 4'h0);
    vecs[17] = v(0, 0, 0, 0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0);
    vecs[18] = v(0, 0, 0, 0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 1, 0, 4'h0);
    vecs[19] = v(0, 0, 0, 0, 4'h0, 1, 0, 0, 4'h0, 0, 1, 1, 1, 4'h3);
    vecs[20] = v(0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h3);

    drive(vecs[0]);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk); #1;
      check($sformatf("v%0d_ack0", i), {3'b0, bus_if.ack0}, {3'b0, vecs[i].ack0});
      check($sformatf("v%0d_ack1", i), {3'b0, bus_if.ack1}, {3'b0, vecs[i].ack1});
      check($sformatf("v%0d_busy", i), {3'b0, bus_if.busy}, {3'b0, vecs[i].busy});
      if (vecs[i].chk_rd)
        check($sformatf("v%0d_rdata", i), bus_if.rdata, vecs[i].rdata);
    end

    // Round-robin: both held for four transactions, prio favours 0 here.
    @(negedge clk);
    bus_if.req0 = 1'b1; bus_if.rw0 = 1'b0; bus_if.addr0 = 1'b0;
    bus_if.req1 = 1'b1; bus_if.rw1 = 1'b0; bus_if.addr1 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      logic e0, e1;
      @(posedge clk); #1;
      e0 = (c == 1 || c == 7);
      e1 = (c == 4 || c == 10);
      check($sformatf("rr%0d_ack0", c), {3'b0, bus_if.ack0}, {3'b0, e0});
      check($sformatf("rr%0d_ack1", c), {3'b0, bus_if.ack1}, {3'b0, e1});
      if (e0 || e1) check($sformatf("rr%0d_rdata", c), bus_if.rdata, 4'h3);
    end
    check("rr_end_busy", {3'b0, bus_if.busy}, 4'h0);
    @(negedge clk);
    bus_if.req0 = 1'b0;
    bus_if.req1 = 1'b0;
    @(posedge clk); #1;

    // Command latching: inputs change during ACCESS.
    @(negedge clk);
    bus_if.req0 = 1'b1; bus_if.rw0 = 1'b1; bus_if.addr0 = 1'b0; bus_if.wdata0 = 4'h6;
    @(posedge clk); #1;
    check("latch_busy", {3'b0, bus_if.busy}, 4'h1);
    @(negedge clk);
    bus_if.addr0 = 1'b1; bus_if.wdata0 = 4'hF;
    @(posedge clk); #1;
    check("latch_ack0", {3'b0, bus_if.ack0}, 4'h1);
    @(negedge clk);
    bus_if.req0 = 1'b0; bus_if.rw0 = 1'b0;
    @(posedge clk); #1;
    do_read(1'b0, 4'h6, "latch_rd0");
    do_read(1'b1, 4'h0, "latch_rd1");

    // Abort: reset during ACCESS of a write.
    @(negedge clk);
    bus_if.req0 = 1'b1; bus_if.rw0 = 1'b1; bus_if.addr0 = 1'b1; bus_if.wdata0 = 4'h5;
    @(posedge clk); #1;
    check("abort_busy_access", {3'b0, bus_if.busy}, 4'h1);
    @(negedge clk);
    clr = 1'b1;
    bus_if.req0 = 1'b0; bus_if.rw0 = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", {3'b0, bus_if.busy}, 4'h0);
    check("abort_ack0", {3'b0, bus_if.ack0}, 4'h0);
    @(negedge clk);
    clr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("abort_quiet%0d_ack0", c), {3'b0, bus_if.ack0}, 4'h0);
      check($sformatf("abort_quiet%0d_busy", c), {3'b0, bus_if.busy}, 4'h0);
    end
    do_read(1'b1, 4'h0, "abort_rd1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
